seg_shift_rx: RTL and testbench

Receive-side model of the serial seven-segment display link: samples SEGCLK/SEGCLR/SEGDT/SEGEN, produced by the display driver in `top`, in the sysclk domain. Reassembles each 64-bit shift frame (8 digits × 8 segment bits) and presents it with a one-cycle valid strobe. Used as the on-chip loopback checker and as the bench-side monitor for display traffic.

---
 rtl/seg_shift_rx.sv | 165 ++++++++++++++++
 tb/tb_seg_shift_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_shift_rx.sv
// Receive side of the serial seven-segment link: synchronizes SEGCLK/SEGCLR/SEGDT/SEGEN
// and reassembles FRAME_BITS-bit frames. Optional digit decode enabled by macro SEG_DECODE_EN.
module seg_shift_rx #(
  parameter int FRAME_BITS = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic                    SEGCLK,
  input  logic                    SEGCLR,
  input  logic                    SEGDT,
  input  logic                    SEGEN,
  output logic [FRAME_BITS-1:0]   frame_data,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    busy
`ifdef SEG_DECODE_EN
  ,
  output logic [FRAME_BITS/2-1:0] digit_hex,
  output logic [FRAME_BITS/8-1:0] digit_ok
`endif
);

  localparam int CNT_W  = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                  state, state_next;
  logic [2:0]              clk_q;
  logic [1:0]              clr_q, dt_q, en_q;
  logic [FRAME_BITS-1:0]   shift, shift_next;
  logic [CNT_W-1:0]        bit_cnt, cnt_next;
  logic [IDLE_W-1:0]       idle_cnt, idle_next;
  logic                    done, done_next, err_next;
  logic                    clr_act, accept, last;

  // Stage 1/2 synchronize; clk_q[2] is the previous synchronized SEGCLK for edge detect.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      clk_q <= 3'b000;
      clr_q <= 2'b00;
      dt_q  <= 2'b00;
      en_q  <= 2'b00;
    end else begin
      clk_q <= {clk_q[1:0], SEGCLK};
      clr_q <= {clr_q[0], SEGCLR};
      dt_q  <= {dt_q[0], SEGDT};
      en_q  <= {en_q[0], SEGEN};
    end
  end

  assign clr_act = ~clr_q[1];
  assign accept  = clk_q[1] & ~clk_q[2] & en_q[1] & clr_q[1];
  assign last    = accept && (bit_cnt == CNT_LAST);

  always_ff @(posedge sysclk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Clear beats an edge; an edge beats a timeout in the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    idle_next  = idle_cnt;
    shift_next = shift;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (clr_act) begin
      state_next = IDLE;
      cnt_next   = '0;
      idle_next  = '0;
      shift_next = '0;
    end else if (accept) begin
      shift_next = {shift[FRAME_BITS-2:0], dt_q[1]};
      idle_next  = '0;
      if (last) begin
        state_next = IDLE;
        cnt_next   = '0;
        done_next  = 1'b1;
      end else begin
        state_next = SHIFT;
        cnt_next   = bit_cnt + CNT_W'(1);
      end
    end else begin
      case (state)
        SHIFT: begin
          if (idle_cnt == IDLE_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
            idle_next  = '0;
            err_next   = 1'b1;
          end else begin
            idle_next = idle_cnt + IDLE_W'(1);
          end
        end
        default: idle_next = '0;
      endcase
    end
  end

  // Completed shift value is published one cycle after the final edge.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      shift       <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      done        <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      shift       <= shift_next;
      bit_cnt     <= cnt_next;
      idle_cnt    <= idle_next;
      done        <= done_next;
      frame_valid <= done;
      frame_err   <= err_next;
      busy        <= (cnt_next != '0);
      if (done) frame_data <= shift;
    end
  end

`ifdef SEG_DECODE_EN
  // Active-low segments, dp ignored: returns {match, hex}.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  // Decode stage trails frame_valid by one cycle.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      digit_hex <= '0;
      digit_ok  <= '0;
    end else if (frame_valid) begin
      for (int k = 0; k < FRAME_BITS / 8; k++) begin
        {digit_ok[k], digit_hex[4*k +: 4]} <= glyph_decode(frame_data[8*k +: 7]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg_shift_rx.sv
// Randomized bench for seg_shift_rx: a bit-level link model predicts frames, errors and timing.
module tb_seg_shift_rx;
  localparam int FB = 64;
  localparam int TO = 1024;

  logic          sysclk = 1'b0;
  logic          rst, SEGCLK, SEGCLR, SEGDT, SEGEN;
  logic [FB-1:0] frame_data;
  logic          frame_valid, frame_err, busy;
`ifdef SEG_DECODE_EN
  logic [FB/2-1:0] digit_hex;
  logic [FB/8-1:0] digit_ok;
`endif

  seg_shift_rx #(.FRAME_BITS(FB), .TIMEOUT(TO)) dut (
    .sysclk(sysclk), .rst(rst), .SEGCLK(SEGCLK), .SEGCLR(SEGCLR), .SEGDT(SEGDT), .SEGEN(SEGEN),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
`ifdef SEG_DECODE_EN
    , .digit_hex(digit_hex), .digit_ok(digit_ok)
`endif
  );

  always #5 sysclk = ~sysclk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Link model: bits accepted since the last frame/clear/timeout/reset.
  logic [FB-1:0] m_shift = '0;
  int            m_cnt = 0;
  logic [FB-1:0] exp_q[$];
  int exp_valid = 0, exp_err = 0, n_valid = 0, n_err = 0;
  int last_rise = 0, prev_valid = -1;
  bit b2b_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  // One SEGCLK period = 8 sysclk: data set while low, 4 low, 4 high.
  task automatic send_bit(input logic b);
    SEGDT = b;
    wait_cyc(4);
    SEGCLK = 1'b1;
    last_rise = cyc;
    if (SEGEN && SEGCLR) begin
      m_shift = {m_shift[FB-2:0], b};
      m_cnt++;
      if (m_cnt == FB) begin
        exp_q.push_back(m_shift);
        exp_valid++;
        m_cnt = 0;
      end
    end
    wait_cyc(4);
    SEGCLK = 1'b0;
  endtask

  task automatic send_bits(input logic [FB-1:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  function automatic logic [FB-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

`ifdef SEG_DECODE_EN
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  function automatic logic [FB/2+FB/8-1:0] ref_decode(input logic [FB-1:0] f);
    logic [FB/2-1:0] h = '0;
    logic [FB/8-1:0] ok = '0;
    for (int k = 0; k < FB/8; k++)
      for (int g = 0; g < 16; g++)
        if (f[8*k +: 7] == glyph[g][6:0]) begin
          h[4*k +: 4] = 4'(g);
          ok[k] = 1'b1;
        end
    return {ok, h};
  endfunction
  bit            dec_pend = 1'b0;
  logic [FB-1:0] dec_frame;
`endif

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge sysclk);
    if (!rst) begin
`ifdef SEG_DECODE_EN
      if (dec_pend) begin
        check("digit_decode", {digit_ok, digit_hex}, ref_decode(dec_frame));
        dec_pend = 1'b0;
      end
`endif
      if (frame_valid) begin
        n_valid++;
        check("valid_count", n_valid, exp_valid);
        if (exp_q.size() > 0) check("frame_data", frame_data, exp_q.pop_front());
        check("valid_latency", cyc - last_rise, 4);
        if (b2b_mode && prev_valid >= 0) check("b2b_gap", cyc - prev_valid, 8 * FB);
        prev_valid = cyc;
`ifdef SEG_DECODE_EN
        dec_pend  = 1'b1;
        dec_frame = frame_data;
`endif
      end
      if (frame_err) n_err++;
    end
  end

  logic [FB-1:0] held;

  initial begin
    rst = 1'b1; SEGCLK = 1'b0; SEGCLR = 1'b1; SEGDT = 1'b0; SEGEN = 1'b1;
    wait_cyc(3);
    @(negedge sysclk);
    check("rst_frame_data", frame_data, '0);
    check("rst_outputs", {frame_valid, frame_err, busy}, 3'b000);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(4);

    // Glyph frame
    send_bits(64'hC0F9A4B0999282F8, FB);
    wait_cyc(10);
    check("t1_valid", n_valid, 1);
    check("t1_busy", busy, 1'b0);
    check("t1_data", frame_data, 64'hC0F9A4B0999282F8);
`ifdef SEG_DECODE_EN
    check("t1_hex", digit_hex, 32'h01234567);
    check("t1_ok", digit_ok, 8'hFF);
`endif

    // Partial frame aborted by timeout
    held = frame_data;
    send_bits(rnd64(), 20);
    wait_cyc(2);
    check("t2_busy_partial", busy, 1'b1);
    wait_cyc(TO + 10);
    m_cnt = 0;
    exp_err++;
    check("t2_err", n_err, exp_err);
    check("t2_valid", n_valid, exp_valid);
    check("t2_hold", frame_data, held);
    check("t2_busy", busy, 1'b0);
    send_bits(rnd64(), FB);
    wait_cyc(10);
    check("t2_recover", n_valid, exp_valid);

    // SEGCLR mid-frame
    send_bits(rnd64(), 30);
    SEGCLR = 1'b0;
    wait_cyc(4);
    SEGCLR = 1'b1;
    m_cnt = 0;
    wait_cyc(4);
    check("t3_busy_cleared", busy, 1'b0);
    send_bits(rnd64(), FB);
    wait_cyc(10);
    check("t3_err", n_err, exp_err);
    check("t3_valid", n_valid, exp_valid);

    // SEGEN low pauses acceptance
    send_bits(rnd64(), 24);
    SEGEN = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < 16; i++) send_bit(1'($urandom));
    check("t4_busy_paused", busy, 1'b1);
    check("t4_no_valid", n_valid, exp_valid);
    SEGEN = 1'b1;
    wait_cyc(4);
    send_bits(rnd64(), FB - 24);
    wait_cyc(10);
    check("t4_valid", n_valid, exp_valid);

    // Back-to-back frames
    b2b_mode = 1'b1;
    prev_valid = -1;
    send_bits(rnd64(), FB);
    send_bits(rnd64(), FB);
    wait_cyc(10);
    b2b_mode = 1'b0;
    check("t5_valid", n_valid, exp_valid);

    // Reset mid-frame
    send_bits(rnd64(), 40);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    m_cnt = 0;
    @(negedge sysclk);
    check("t6_frame_data", frame_data, '0);
    check("t6_outputs", {frame_valid, frame_err, busy}, 3'b000);
    wait_cyc(4);
    send_bits(rnd64(), FB);
    wait_cyc(10);
    check("t6_valid", n_valid, exp_valid);

    for (int f = 0; f < 3; f++) send_bits(rnd64(), FB);
    wait_cyc(10);
    check("total_valid", n_valid, exp_valid);
    check("total_err", n_err, exp_err);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
